// File: rtl/fast_bconv_sk_pkg.sv
// Shared types, moduli and precomputed CRT constants for the B∪{m_sk} -> q base converter.
// The LUT constants are derived from the moduli by constant functions so they cannot drift apart.
package fast_bconv_sk_pkg;

  typedef logic [31:0] rns_residue_t;
  typedef logic [63:0] wide_rns_residue_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_GAMMA,
    ST_CORRECT,
    ST_DONE
  } bconv_state_t;

  localparam int B_BASIS_LEN = 4;
  localparam int q_BASIS_LEN = 3;

  localparam rns_residue_t B_BASIS [B_BASIS_LEN] = '{32'd257, 32'd65537, 32'd131071, 32'd524287};
  localparam rns_residue_t q_BASIS [q_BASIS_LEN] = '{32'd2147483647, 32'd1000003, 32'd40961};
  localparam rns_residue_t m_SK = 32'd31;

  function automatic rns_residue_t add_mod(input rns_residue_t a, input rns_residue_t b,
                                           input rns_residue_t m);
    wide_rns_residue_t s;
    s = wide_rns_residue_t'(a) + wide_rns_residue_t'(b);
    if (s >= wide_rns_residue_t'(m)) s = s - wide_rns_residue_t'(m);
    return rns_residue_t'(s);
  endfunction

  function automatic rns_residue_t sub_mod(input rns_residue_t a, input rns_residue_t b,
                                           input rns_residue_t m);
    wide_rns_residue_t s;
    if (a >= b) s = wide_rns_residue_t'(a) - wide_rns_residue_t'(b);
    else        s = wide_rns_residue_t'(a) + wide_rns_residue_t'(m) - wide_rns_residue_t'(b);
    return rns_residue_t'(s);
  endfunction

  // (B / b_skip) mod m; a negative skip yields B mod m.
  function automatic rns_residue_t prod_mod(input int skip, input rns_residue_t m);
    wide_rns_residue_t r;
    r = 64'd1 % wide_rns_residue_t'(m);
    for (int i = 0; i < B_BASIS_LEN; i++)
      if (i != skip)
        r = (r * (wide_rns_residue_t'(B_BASIS[i]) % wide_rns_residue_t'(m))) % wide_rns_residue_t'(m);
    return rns_residue_t'(r);
  endfunction

  function automatic rns_residue_t mod_inv(input rns_residue_t a, input rns_residue_t m);
    longint t, t_new, r, r_new, q, tmp;
    t     = 0;
    t_new = 1;
    r     = longint'({32'd0, m});
    r_new = longint'({32'd0, a}) % r;
    while (r_new != 0) begin
      q     = r / r_new;
      tmp   = t - q * t_new;
      t     = t_new;
      t_new = tmp;
      tmp   = r - q * r_new;
      r     = r_new;
      r_new = tmp;
    end
    if (t < 0) t = t + longint'({32'd0, m});
    return rns_residue_t'(t);
  endfunction

  localparam rns_residue_t z_MOD_B [B_BASIS_LEN] = '{
    mod_inv(prod_mod(0, B_BASIS[0]), B_BASIS[0]),
    mod_inv(prod_mod(1, B_BASIS[1]), B_BASIS[1]),
    mod_inv(prod_mod(2, B_BASIS[2]), B_BASIS[2]),
    mod_inv(prod_mod(3, B_BASIS[3]), B_BASIS[3])};

  localparam rns_residue_t y_B_TO_q [q_BASIS_LEN][B_BASIS_LEN] = '{
    '{prod_mod(0, q_BASIS[0]), prod_mod(1, q_BASIS[0]), prod_mod(2, q_BASIS[0]), prod_mod(3, q_BASIS[0])},
    '{prod_mod(0, q_BASIS[1]), prod_mod(1, q_BASIS[1]), prod_mod(2, q_BASIS[1]), prod_mod(3, q_BASIS[1])},
    '{prod_mod(0, q_BASIS[2]), prod_mod(1, q_BASIS[2]), prod_mod(2, q_BASIS[2]), prod_mod(3, q_BASIS[2])}};

  localparam rns_residue_t y_B_TO_msk [B_BASIS_LEN] = '{
    prod_mod(0, m_SK), prod_mod(1, m_SK), prod_mod(2, m_SK), prod_mod(3, m_SK)};

  localparam rns_residue_t Binv_MOD_msk = mod_inv(prod_mod(-1, m_SK), m_SK);

  localparam rns_residue_t B_MOD_q [q_BASIS_LEN] = '{
    prod_mod(-1, q_BASIS[0]), prod_mod(-1, q_BASIS[1]), prod_mod(-1, q_BASIS[2])};

endpackage

// File: rtl/rns_modmul.sv
// Combinational modular multiply (a*b) mod m through a full-width product.
module rns_modmul
  import fast_bconv_sk_pkg::*;
(
  input  rns_residue_t i_a,
  input  rns_residue_t i_b,
  input  rns_residue_t i_m,
  output rns_residue_t o_p
);

  wide_rns_residue_t w_prod;

  assign w_prod = wide_rns_residue_t'(i_a) * wide_rns_residue_t'(i_b);
  assign o_p    = rns_residue_t'(w_prod % wide_rns_residue_t'(i_m));

endmodule

// File: rtl/fast_bconv_sk.sv
// Exact Shenoy-Kumaresan base conversion: one source residue per ACCUM cycle,
// then a gamma correction that removes the B-multiple overflow from every destination lane.
module fast_bconv_sk
  import fast_bconv_sk_pkg::*;
#(
  parameter int           IN_BASIS_LEN                              = B_BASIS_LEN,
  parameter int           OUT_BASIS_LEN                             = q_BASIS_LEN,
  parameter rns_residue_t IN_BASIS  [IN_BASIS_LEN]                  = B_BASIS,
  parameter rns_residue_t OUT_BASIS [OUT_BASIS_LEN]                 = q_BASIS,
  parameter rns_residue_t M_SK                                      = m_SK,
  parameter rns_residue_t ZiLUT     [IN_BASIS_LEN]                  = z_MOD_B,
  parameter rns_residue_t YMODQ     [OUT_BASIS_LEN][IN_BASIS_LEN]   = y_B_TO_q,
  parameter rns_residue_t YMODSK    [IN_BASIS_LEN]                  = y_B_TO_msk,
  parameter rns_residue_t BINV_SK                                   = Binv_MOD_msk,
  parameter rns_residue_t BMODQ     [OUT_BASIS_LEN]                 = B_MOD_q
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  rns_residue_t input_RNSint  [IN_BASIS_LEN],
  input  rns_residue_t input_sk,
  output logic         in_ready,
  output logic         out_valid,
  output rns_residue_t output_RNSint [OUT_BASIS_LEN]
);

  localparam int IDX_W = (IN_BASIS_LEN > 1) ? $clog2(IN_BASIS_LEN) : 1;

  bconv_state_t r_state, w_next_state;
  logic [IDX_W-1:0] r_idx;
  rns_residue_t r_x [IN_BASIS_LEN];
  rns_residue_t r_x_sk;
  rns_residue_t r_acc [OUT_BASIS_LEN];
  rns_residue_t r_acc_sk;
  rns_residue_t r_gamma_abs;
  logic         r_gamma_neg;
  rns_residue_t r_out [OUT_BASIS_LEN];

  logic         w_last;
  rns_residue_t w_a;
  rns_residue_t w_sk_a, w_sk_b, w_sk_p;
  rns_residue_t w_lane_a [OUT_BASIS_LEN];
  rns_residue_t w_lane_b [OUT_BASIS_LEN];
  rns_residue_t w_lane_p [OUT_BASIS_LEN];

  assign w_last = (r_idx == IDX_W'(IN_BASIS_LEN - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (in_valid) w_next_state = ST_ACCUM;
      ST_ACCUM:   if (w_last)   w_next_state = ST_GAMMA;
      ST_GAMMA:   w_next_state = ST_CORRECT;
      ST_CORRECT: w_next_state = ST_DONE;
      ST_DONE:    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  rns_modmul u_mul_a (
    .i_a (r_x[r_idx]),
    .i_b (ZiLUT[r_idx]),
    .i_m (IN_BASIS[r_idx]),
    .o_p (w_a)
  );

  // Lane multipliers are shared: accumulation terms in ACCUM, gamma*B^-1 in GAMMA, |gamma_c|*B in CORRECT.
  always_comb begin
    w_sk_a = (r_state == ST_GAMMA) ? sub_mod(r_acc_sk, r_x_sk, M_SK) : w_a;
    w_sk_b = (r_state == ST_GAMMA) ? BINV_SK : YMODSK[r_idx];
    for (int j = 0; j < OUT_BASIS_LEN; j++) begin
      w_lane_a[j] = (r_state == ST_CORRECT) ? r_gamma_abs : w_a;
      w_lane_b[j] = (r_state == ST_CORRECT) ? BMODQ[j] : YMODQ[j][r_idx];
    end
  end

  rns_modmul u_mul_sk (
    .i_a (w_sk_a),
    .i_b (w_sk_b),
    .i_m (M_SK),
    .o_p (w_sk_p)
  );

  for (genvar j = 0; j < OUT_BASIS_LEN; j++) begin : g_lane
    rns_modmul u_mul_q (
      .i_a (w_lane_a[j]),
      .i_b (w_lane_b[j]),
      .i_m (OUT_BASIS[j]),
      .o_p (w_lane_p[j])
    );
  end

  // NOTE: the input snapshot is not reset; it is always loaded before ACCUM reads it.
  always_ff @(posedge clk) begin
    if (!reset && r_state == ST_IDLE && in_valid) begin
      r_x    <= input_RNSint;
      r_x_sk <= input_sk;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx       <= '0;
      r_acc_sk    <= '0;
      r_gamma_abs <= '0;
      r_gamma_neg <= 1'b0;
      for (int j = 0; j < OUT_BASIS_LEN; j++) begin
        r_acc[j] <= '0;
        r_out[j] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_idx    <= '0;
          r_acc_sk <= '0;
          for (int j = 0; j < OUT_BASIS_LEN; j++) r_acc[j] <= '0;
        end
        ST_ACCUM: begin
          r_idx    <= w_last ? '0 : r_idx + 1'b1;
          r_acc_sk <= add_mod(r_acc_sk, w_sk_p, M_SK);
          for (int j = 0; j < OUT_BASIS_LEN; j++)
            r_acc[j] <= add_mod(r_acc[j], w_lane_p[j], OUT_BASIS[j]);
        end
        ST_GAMMA: begin
          // Upper half of [0, M_SK) stands for a negative gamma; keep its magnitude and sign.
          if (w_sk_p > (M_SK >> 1)) begin
            r_gamma_neg <= 1'b1;
            r_gamma_abs <= M_SK - w_sk_p;
          end else begin
            r_gamma_neg <= 1'b0;
            r_gamma_abs <= w_sk_p;
          end
        end
        ST_CORRECT: begin
          for (int j = 0; j < OUT_BASIS_LEN; j++)
            r_out[j] <= r_gamma_neg ? add_mod(r_acc[j], w_lane_p[j], OUT_BASIS[j])
                                    : sub_mod(r_acc[j], w_lane_p[j], OUT_BASIS[j]);
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = (r_state == ST_IDLE);
  assign out_valid     = (r_state == ST_DONE);
  assign output_RNSint = r_out;

endmodule
